// File: rtl/sprite_engine.sv
// sprite_engine: draws a SPRITE_W x SPRITE_H block, waits a number of frame
// ticks, erases it, moves it one step and bounces it off the screen edges.
module sprite_engine #(
    parameter int SPRITE_W        = 4,
    parameter int SPRITE_H        = 4,
    parameter int SCREEN_W        = 160,
    parameter int SCREEN_H        = 120,
    parameter int X_BITS          = 8,
    parameter int Y_BITS          = 7,
    parameter int TICK_DIV        = 833333,
    parameter int FRAMES_PER_MOVE = 15,
    parameter int STEP            = 1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic              halt,
    input  logic [X_BITS-1:0] x_init,
    input  logic [Y_BITS-1:0] y_init,
    input  logic              dx_init,
    input  logic              dy_init,
    input  logic [2:0]        colour_in,
    output logic [X_BITS-1:0] x_out,
    output logic [Y_BITS-1:0] y_out,
    output logic [2:0]        colour,
    output logic              plot,
    output logic              busy,
    output logic              bounce
);

    localparam int PIX        = SPRITE_W * SPRITE_H;
    localparam int PCNT_BITS  = (PIX > 1) ? $clog2(PIX) : 1;
    localparam int TICK_BITS  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int FRAME_BITS = (FRAMES_PER_MOVE > 1) ? $clog2(FRAMES_PER_MOVE) : 1;

    localparam logic [X_BITS-1:0]     XMAX_V     = X_BITS'(SCREEN_W - SPRITE_W);
    localparam logic [Y_BITS-1:0]     YMAX_V     = Y_BITS'(SCREEN_H - SPRITE_H);
    localparam logic [X_BITS:0]       X_STEP     = (X_BITS + 1)'(STEP);
    localparam logic [Y_BITS:0]       Y_STEP     = (Y_BITS + 1)'(STEP);
    localparam logic [X_BITS-1:0]     PX_LAST    = X_BITS'(SPRITE_W - 1);
    localparam logic [PCNT_BITS-1:0]  PCNT_LAST  = PCNT_BITS'(PIX - 1);
    localparam logic [TICK_BITS-1:0]  TICK_LAST  = TICK_BITS'(TICK_DIV - 1);
    localparam logic [FRAME_BITS-1:0] FRAME_LAST = FRAME_BITS'(FRAMES_PER_MOVE - 1);
    localparam logic [PCNT_BITS-1:0]  PCNT_ONE   = PCNT_BITS'(1);
    localparam logic [X_BITS-1:0]     PX_ONE     = X_BITS'(1);
    localparam logic [Y_BITS-1:0]     PY_ONE     = Y_BITS'(1);
    localparam logic [TICK_BITS-1:0]  TICK_ONE   = TICK_BITS'(1);
    localparam logic [FRAME_BITS-1:0] FRAME_ONE  = FRAME_BITS'(1);

    typedef enum logic [2:0] {IDLE, LOAD, DRAW, WAIT, ERASE, MOVE} state_t;

    state_t                state_reg, state_next;
    logic [X_BITS-1:0]     x_reg, px_reg, x_next;
    logic [Y_BITS-1:0]     y_reg, py_reg, y_next;
    logic                  dx_reg, dy_reg, halt_reg;
    logic [2:0]            colour_reg;
    logic [PCNT_BITS-1:0]  pcnt_reg;
    logic [TICK_BITS-1:0]  tick_reg;
    logic [FRAME_BITS-1:0] frame_reg;
    logic [X_BITS:0]       x_up;
    logic [Y_BITS:0]       y_up;
    logic                  x_flip, y_flip;
    logic                  last_pix, tick_done, move_done, plotting;

    assign plotting  = (state_reg == DRAW) || (state_reg == ERASE);
    assign last_pix  = (pcnt_reg == PCNT_LAST);
    assign tick_done = (tick_reg == TICK_LAST);
    assign move_done = tick_done && (frame_reg == FRAME_LAST);
    assign x_up      = {1'b0, x_reg} + X_STEP;
    assign y_up      = {1'b0, y_reg} + Y_STEP;

    // Next position and edge bounces, applied only when in MOVE.
    always_comb begin
        x_next = x_reg;
        x_flip = 1'b0;
        y_next = y_reg;
        y_flip = 1'b0;
        if (dx_reg) begin
            if (x_up >= {1'b0, XMAX_V}) begin
                x_next = XMAX_V;
                x_flip = 1'b1;
            end else begin
                x_next = x_up[X_BITS-1:0];
            end
        end else if ({1'b0, x_reg} <= X_STEP) begin
            x_next = '0;
            x_flip = 1'b1;
        end else begin
            x_next = x_reg - X_STEP[X_BITS-1:0];
        end
        if (dy_reg) begin
            if (y_up >= {1'b0, YMAX_V}) begin
                y_next = YMAX_V;
                y_flip = 1'b1;
            end else begin
                y_next = y_up[Y_BITS-1:0];
            end
        end else if ({1'b0, y_reg} <= Y_STEP) begin
            y_next = '0;
            y_flip = 1'b1;
        end else begin
            y_next = y_reg - Y_STEP[Y_BITS-1:0];
        end
    end

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state_reg <= IDLE;
        else         state_reg <= state_next;
    end

    // Next-state logic; a captured halt ends the animation after the erase.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start && !halt) state_next = LOAD;
            LOAD:    state_next = DRAW;
            DRAW:    if (last_pix) state_next = WAIT;
            WAIT:    if (halt || move_done) state_next = ERASE;
            ERASE:   if (last_pix) state_next = halt_reg ? IDLE : MOVE;
            MOVE:    state_next = DRAW;
            default: state_next = IDLE;
        endcase
    end

    // Position, direction, colour, halt capture and all counters.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            x_reg      <= '0;
            y_reg      <= '0;
            dx_reg     <= 1'b0;
            dy_reg     <= 1'b0;
            colour_reg <= '0;
            halt_reg   <= 1'b0;
            pcnt_reg   <= '0;
            px_reg     <= '0;
            py_reg     <= '0;
            tick_reg   <= '0;
            frame_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: halt_reg <= 1'b0;
                LOAD: begin
                    x_reg      <= (x_init > XMAX_V) ? XMAX_V : x_init;
                    y_reg      <= (y_init > YMAX_V) ? YMAX_V : y_init;
                    dx_reg     <= dx_init;
                    dy_reg     <= dy_init;
                    colour_reg <= colour_in;
                    halt_reg   <= 1'b0;
                end
                WAIT: if (halt) halt_reg <= 1'b1;
                MOVE: begin
                    x_reg      <= x_next;
                    y_reg      <= y_next;
                    dx_reg     <= dx_reg ^ x_flip;
                    dy_reg     <= dy_reg ^ y_flip;
                    colour_reg <= colour_in;
                end
                default: ;
            endcase

            if (plotting && !last_pix) begin
                pcnt_reg <= pcnt_reg + PCNT_ONE;
                if (px_reg == PX_LAST) begin
                    px_reg <= '0;
                    py_reg <= py_reg + PY_ONE;
                end else begin
                    px_reg <= px_reg + PX_ONE;
                end
            end else begin
                pcnt_reg <= '0;
                px_reg   <= '0;
                py_reg   <= '0;
            end

            if (state_reg == WAIT && !move_done) begin
                if (tick_done) begin
                    tick_reg  <= '0;
                    frame_reg <= frame_reg + FRAME_ONE;
                end else begin
                    tick_reg <= tick_reg + TICK_ONE;
                end
            end else begin
                tick_reg  <= '0;
                frame_reg <= '0;
            end
        end
    end

    // Pixel outputs: sprite pixel while plotting, stored position otherwise.
    always_comb begin
        plot   = plotting;
        busy   = (state_reg != IDLE);
        bounce = (state_reg == MOVE) && (x_flip || y_flip);
        colour = (state_reg == DRAW) ? colour_reg : 3'b000;
        x_out  = plotting ? x_reg + px_reg : x_reg;
        y_out  = plotting ? y_reg + py_reg : y_reg;
    end

endmodule
